// File: rtl/axi_lite_read_xbar.sv
// -----------------------------------------------------------------------------
// axi_lite_read_xbar
//
// AXI4-Lite read-only crossbar with one master and two slaves. It sits in front
// of the CLINT. The master address is decoded against a base/mask window:
// addresses inside the CLINT window go to slave 0, and all other addresses go
// to slave 1 (the SoC memory/peripheral bus).
//
// Only one transaction is in flight at a time. A response timeout returns
// SLVERR to the master, so a hung slave cannot stall the core forever.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   m_ar*/m_r*                master-side read address / read data channels
//   s0_ar*/s0_r*              slave 0 (CLINT) read channels
//   s1_ar*/s1_r*              slave 1 (default slave) read channels
//
// Parameters:
//   CLINT_BASE, CLINT_MASK    slave 0 decode window
//   TIMEOUT                   cycles from leaving IDLE to forced SLVERR (0 = off)
//   CNT_W                     timeout counter width (TIMEOUT < 2**CNT_W)
// -----------------------------------------------------------------------------
module axi_lite_read_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
  parameter int          TIMEOUT    = 256,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m_arvalid,
  output logic        m_arready,
  input  logic [31:0] m_araddr,
  output logic        m_rvalid,
  input  logic        m_rready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,

  output logic        s0_arvalid,
  input  logic        s0_arready,
  output logic [31:0] s0_araddr,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,

  output logic        s1_arvalid,
  input  logic        s1_arready,
  output logic [31:0] s1_araddr,
  input  logic        s1_rvalid,
  output logic        s1_rready,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  // Last counter value before the timeout fires. This value is unused when
  // TIMEOUT is 0, because timeout_hit is then forced low.
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [31:0]      addr_r;
  logic             sel;          // 0 = CLINT, 1 = default slave
  logic [CNT_W-1:0] cnt;

  logic             sel_next;
  logic             sl_arready;
  logic             sl_rvalid;
  logic [31:0]      sl_rdata;
  logic [1:0]       sl_rresp;
  logic             r_done;
  logic             timeout_hit;

  assign sel_next = ((m_araddr & CLINT_MASK) == CLINT_BASE) ? 1'b0 : 1'b1;

  // Return-path signals of the slave chosen by the latched sel.
  assign sl_arready = sel ? s1_arready : s0_arready;
  assign sl_rvalid  = sel ? s1_rvalid  : s0_rvalid;
  assign sl_rdata   = sel ? s1_rdata   : s0_rdata;
  assign sl_rresp   = sel ? s1_rresp   : s0_rresp;

  assign r_done      = (state == R) && sl_rvalid && m_rready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // NOTE: state registers use non-blocking assignments only. Blocking
  // assignments here would create ordering races with other always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_r <= '0;
      sel    <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && m_arvalid) begin
        addr_r <= m_araddr;
        sel    <= sel_next;
        cnt    <= '0;
      end else if (state == AR || state == R) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A completed R handshake takes priority over a timeout in the same cycle.
  // A timeout in AR always wins, because no data can have been returned yet.
  // NOTE: every always_comb assigns defaults first, so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (m_arvalid)        state_next = AR;
      AR: begin
        if (timeout_hit)          state_next = ERR;
        else if (sl_arready)      state_next = R;
      end
      R: begin
        if (r_done)               state_next = IDLE;
        else if (timeout_hit)     state_next = ERR;
      end
      ERR: if (m_rready)          state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Outputs are driven only from state, sel and addr_r, plus the
  // pass-through inputs in R. They are forced to 0 while rst is high.
  always_comb begin
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = '0;
    s0_arvalid = 1'b0;
    s0_araddr  = '0;
    s0_rready  = 1'b0;
    s1_arvalid = 1'b0;
    s1_araddr  = '0;
    s1_rready  = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: m_arready = 1'b1;
        AR: begin
          if (sel) begin
            s1_arvalid = 1'b1;
            s1_araddr  = addr_r;
          end else begin
            s0_arvalid = 1'b1;
            s0_araddr  = addr_r;
          end
        end
        R: begin
          m_rvalid = sl_rvalid;
          m_rdata  = sl_rdata;
          m_rresp  = sl_rresp;
          if (sel) s1_rready = m_rready;
          else     s0_rready = m_rready;
        end
        ERR: begin
          // Constant error beat. The abandoned slave is never acknowledged.
          m_rvalid = 1'b1;
          m_rresp  = RESP_SLVERR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_read_xbar.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_read_xbar
//
// Directed self-checking bench for axi_lite_read_xbar with TIMEOUT = 16.
// Inputs are driven 1 ns after the rising edge. Outputs are checked 1 ns
// after that, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_read_xbar;

  logic        clk = 1'b0;
  logic        rst;

  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_araddr, s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s1_araddr, s1_rdata;
  logic [1:0]  s1_rresp;

  int n_checks = 0;
  int n_errors = 0;

  // Sticky observation counters, updated only by the monitor process.
  int cnt_s0_ar = 0;
  int cnt_s0_rr = 0;
  int cnt_s1_ar = 0;
  int cnt_s1_rr = 0;

  always #5 clk = ~clk;

  axi_lite_read_xbar #(
    .CLINT_BASE (32'h0200_0000),
    .CLINT_MASK (32'hFFFF_0000),
    .TIMEOUT    (16),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_araddr   (m_araddr),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .s0_arvalid (s0_arvalid),
    .s0_arready (s0_arready),
    .s0_araddr  (s0_araddr),
    .s0_rvalid  (s0_rvalid),
    .s0_rready  (s0_rready),
    .s0_rdata   (s0_rdata),
    .s0_rresp   (s0_rresp),
    .s1_arvalid (s1_arvalid),
    .s1_arready (s1_arready),
    .s1_araddr  (s1_araddr),
    .s1_rvalid  (s1_rvalid),
    .s1_rready  (s1_rready),
    .s1_rdata   (s1_rdata),
    .s1_rresp   (s1_rresp)
  );

  always @(negedge clk) begin
    if (s0_arvalid) cnt_s0_ar++;
    if (s0_rready)  cnt_s0_rr++;
    if (s1_arvalid) cnt_s1_ar++;
    if (s1_rready)  cnt_s1_rr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one address in IDLE and advance into AR.
  task automatic issue(input logic [31:0] addr);
    m_arvalid = 1'b1;
    m_araddr  = addr;
    #1;
    check("idle_arready", 32'(m_arready), 32'd1);
    step();
    m_arvalid = 1'b0;
    m_araddr  = 32'hDEAD_BEEF;   // ignored outside IDLE
  endtask

  initial begin
    int s0_ar0, s0_rr0, s1_ar0, s1_rr0;
    logic [31:0] held;

    rst        = 1'b1;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_rready   = 1'b0;
    s0_arready = 1'b0; s0_rvalid = 1'b0; s0_rdata = '0; s0_rresp = '0;
    s1_arready = 1'b0; s1_rvalid = 1'b0; s1_rdata = '0; s1_rresp = '0;

    step_n(2);
    check("rst_arready", 32'(m_arready), 32'd0);
    rst = 1'b0;
    #1;

    // ---- Test 1: CLINT read ----------------------------------------------
    s1_ar0 = cnt_s1_ar;
    issue(32'h0200_0008);
    s0_arready = 1'b1;
    #1;
    check("t1_s0_arvalid", 32'(s0_arvalid), 32'd1);
    check("t1_s0_araddr",  s0_araddr, 32'h0200_0008);
    check("t1_s1_araddr",  s1_araddr, 32'h0);
    check("t1_arready_busy", 32'(m_arready), 32'd0);
    step();
    s0_arready = 1'b0;
    m_rready   = 1'b1;
    #1;
    check("t1_rvalid_early", 32'(m_rvalid), 32'd0);
    step();
    s0_rvalid = 1'b1; s0_rdata = 32'h0000_1234; s0_rresp = 2'b00;
    #1;
    check("t1_rvalid", 32'(m_rvalid), 32'd1);
    check("t1_rdata",  m_rdata, 32'h0000_1234);
    check("t1_rresp",  32'(m_rresp), 32'd0);
    check("t1_s0_rready", 32'(s0_rready), 32'd1);
    step();
    s0_rvalid = 1'b0; m_rready = 1'b0;
    #1;
    check("t1_back_idle", 32'(m_arready), 32'd1);
    check("t1_s1_ar_never", 32'(cnt_s1_ar - s1_ar0), 32'd0);

    // ---- Test 2: default-slave read --------------------------------------
    s0_ar0 = cnt_s0_ar; s0_rr0 = cnt_s0_rr;
    m_rready = 1'b1;
    issue(32'h8000_0004);
    s1_arready = 1'b1;
    #1;
    check("t2_s1_arvalid", 32'(s1_arvalid), 32'd1);
    check("t2_s1_araddr",  s1_araddr, 32'h8000_0004);
    step();
    s1_arready = 1'b0;
    s1_rvalid = 1'b1; s1_rdata = 32'hCAFE_F00D; s1_rresp = 2'b00;
    #1;
    check("t2_rdata", m_rdata, 32'hCAFE_F00D);
    check("t2_rresp", 32'(m_rresp), 32'd0);
    check("t2_s1_rready", 32'(s1_rready), 32'd1);
    step();
    s1_rvalid = 1'b0; m_rready = 1'b0;
    #1;
    check("t2_back_idle", 32'(m_arready), 32'd1);
    check("t2_s0_ar_never", 32'(cnt_s0_ar - s0_ar0), 32'd0);
    check("t2_s0_rr_never", 32'(cnt_s0_rr - s0_rr0), 32'd0);

    // ---- Test 3: master backpressure -------------------------------------
    issue(32'h0200_0010);
    s0_arready = 1'b1;
    step();
    s0_arready = 1'b0;
    s0_rvalid = 1'b1; s0_rdata = 32'h55AA_55AA; s0_rresp = 2'b00;
    m_rready  = 1'b0;
    #1;
    held = m_rdata;
    check("t3_first_data", held, 32'h55AA_55AA);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_rvalid", 32'(m_rvalid), 32'd1);
      check("t3_hold_rdata",  m_rdata, held);
      check("t3_hold_rready", 32'(s0_rready), 32'd0);
      step();
    end
    check("t3_still_busy", 32'(m_arready), 32'd0);
    m_rready = 1'b1;
    #1;
    check("t3_s0_rready", 32'(s0_rready), 32'd1);
    step();
    s0_rvalid = 1'b0; m_rready = 1'b0;
    #1;
    check("t3_back_idle", 32'(m_arready), 32'd1);

    // ---- Test 4: timeout on slave 1 --------------------------------------
    s1_rr0 = cnt_s1_rr;
    issue(32'h8000_0000);              // left IDLE at edge E0
    s1_arready = 1'b1;
    step();                             // E1: now R
    s1_arready = 1'b0;
    step_n(14);                         // E15: still R, cnt == 15
    check("t4_pre_err_rvalid", 32'(m_rvalid), 32'd0);
    step();                             // E16: ERR
    check("t4_err_rvalid", 32'(m_rvalid), 32'd1);
    check("t4_err_rdata",  m_rdata, 32'h0);
    check("t4_err_rresp",  32'(m_rresp), 32'd2);
    step();                             // hold ERR under backpressure
    check("t4_err_held", 32'(m_rvalid), 32'd1);
    s1_rvalid = 1'b1; s1_rdata = 32'h1111_2222;   // late response
    m_rready  = 1'b1;
    #1;
    check("t4_late_rready", 32'(s1_rready), 32'd0);
    check("t4_late_rdata",  m_rdata, 32'h0);
    step();
    s1_rvalid = 1'b0; m_rready = 1'b0;
    #1;
    check("t4_back_idle", 32'(m_arready), 32'd1);
    check("t4_s1_rr_never", 32'(cnt_s1_rr - s1_rr0), 32'd0);

    // ---- Test 5: completion ties with timeout ----------------------------
    issue(32'h0200_0014);              // E0
    s0_arready = 1'b1;
    step();                             // E1: R, cnt == 1
    s0_arready = 1'b0;
    step_n(14);                         // E15: cnt == 15
    s0_rvalid = 1'b1; s0_rdata = 32'hABCD_0001; s0_rresp = 2'b00;
    m_rready  = 1'b1;
    #1;
    check("t5_rdata", m_rdata, 32'hABCD_0001);
    check("t5_rresp", 32'(m_rresp), 32'd0);
    step();                             // E16: must be IDLE, not ERR
    s0_rvalid = 1'b0; m_rready = 1'b0;
    #1;
    check("t5_idle_arready", 32'(m_arready), 32'd1);
    check("t5_no_err_rvalid", 32'(m_rvalid), 32'd0);

    // ---- Test 6: reset in R, then a fresh read ---------------------------
    issue(32'h0200_0018);
    s0_arready = 1'b1;
    step();
    s0_arready = 1'b0;
    m_rready = 1'b1;                    // s0_rvalid stays 0
    #1;
    check("t6_in_r_rready", 32'(s0_rready), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {26'd0, m_arready, m_rvalid, s0_arvalid, s0_rready, s1_arvalid, s1_rready}, 32'd0);
    step();
    check("t6_rst_ctrl2", {26'd0, m_arready, m_rvalid, s0_arvalid, s0_rready, s1_arvalid, s1_rready}, 32'd0);
    check("t6_rst_bus", m_rdata | s0_araddr | s1_araddr | 32'(m_rresp), 32'd0);
    rst = 1'b0;
    m_rready = 1'b0;
    #1;
    check("t6_release_arready", 32'(m_arready), 32'd1);
    issue(32'h0200_000C);
    s0_arready = 1'b1;
    #1;
    check("t6_s0_araddr", s0_araddr, 32'h0200_000C);
    step();
    s0_arready = 1'b0;
    s0_rvalid = 1'b1; s0_rdata = 32'h0C0C_0C0C; s0_rresp = 2'b00;
    m_rready  = 1'b1;
    #1;
    check("t6_rdata", m_rdata, 32'h0C0C_0C0C);
    step();
    s0_rvalid = 1'b0; m_rready = 1'b0;
    #1;
    check("t6_back_idle", 32'(m_arready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
